// File: rtl/cbd_poly_buffer.sv
// cbd_poly_buffer: reduces signed CBD coefficient pairs into [0, Q),
// buffers one polynomial and streams it out under a pull handshake.
module cbd_poly_buffer #(
    parameter int Q  = 3329,
    parameter int N  = 256,
    parameter int DW = 12,
    localparam int NP = N / 2,
    localparam int AW = $clog2(NP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set,
    input  logic [15:0]   cbd_din_1,
    input  logic [15:0]   cbd_din_2,
    input  logic          din_valid,
    output logic          ok_in,
    input  logic          readout,
    output logic          ok_out,
    output logic [DW-1:0] dout_1,
    output logic [DW-1:0] dout_2,
    output logic [AW-1:0] dout_addr,
    output logic          dout_valid,
    output logic          done,
    output logic          range_err
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(NP - 1);
    localparam logic signed [16:0] QS  = 17'(Q);
    localparam logic signed [16:0] QM1 = 17'(Q - 1);

    state_t state, state_n;
    logic [AW-1:0] wr_cnt, rd_cnt;
    logic wr_en, pop;
    logic [2*DW-1:0] mem [NP];

    logic signed [16:0] x1, x2, s1, s2;
    logic oor;

    assign x1 = {cbd_din_1[15], cbd_din_1};
    assign x2 = {cbd_din_2[15], cbd_din_2};
    assign s1 = x1[16] ? x1 + QS : x1;
    assign s2 = x2[16] ? x2 + QS : x2;
    assign oor = (x1 > QM1) || (x1 < -QM1) ||
                 (x2 > QM1) || (x2 < -QM1);

    assign ok_in  = (state == FILL);
    assign ok_out = (state == DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // set low overrides everything, including a last-pair pop
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        pop     = 1'b0;
        if (!set) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: state_n = FILL;
                FILL: begin
                    if (din_valid) begin
                        wr_en = 1'b1;
                        if (wr_cnt == LAST) state_n = DRAIN;
                    end
                end
                DRAIN: begin
                    if (readout) begin
                        pop = 1'b1;
                        if (rd_cnt == LAST) state_n = FILL;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt] <= {s1[DW-1:0], s2[DW-1:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            dout_1     <= '0;
            dout_2     <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            dout_valid <= pop;
            done       <= pop && (rd_cnt == LAST);
            if (!set) begin
                wr_cnt    <= '0;
                rd_cnt    <= '0;
                range_err <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + 1'b1;
                    if (oor) range_err <= 1'b1;
                end
                if (pop) begin
                    dout_1    <= mem[rd_cnt][2*DW-1:DW];
                    dout_2    <= mem[rd_cnt][DW-1:0];
                    dout_addr <= rd_cnt;
                    rd_cnt    <= (rd_cnt == LAST) ? '0 : rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cbd_poly_buffer.sv
// tb_cbd_poly_buffer: directed + randomized bench for cbd_poly_buffer
// against an arithmetic model of the reduction and fill/drain order.
module tb_cbd_poly_buffer;

    localparam int Q  = 3329;
    localparam int N  = 256;
    localparam int NP = N / 2;

    logic        clk;
    logic        reset;
    logic        set;
    logic [15:0] cbd_din_1;
    logic [15:0] cbd_din_2;
    logic        din_valid;
    logic        ok_in;
    logic        readout;
    logic        ok_out;
    logic [11:0] dout_1;
    logic [11:0] dout_2;
    logic [6:0]  dout_addr;
    logic        dout_valid;
    logic        done;
    logic        range_err;

    int checks = 0;
    int errors = 0;
    int d1 [NP];
    int d2 [NP];
    bit exp_err = 0;

    cbd_poly_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .cbd_din_1  (cbd_din_1),
        .cbd_din_2  (cbd_din_2),
        .din_valid  (din_valid),
        .ok_in      (ok_in),
        .readout    (readout),
        .ok_out     (ok_out),
        .dout_1     (dout_1),
        .dout_2     (dout_2),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .done       (done),
        .range_err  (range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int red(input int x);
        int r;
        r = (x < 0) ? x + Q : x;
        return r % 4096;
    endfunction

    function automatic bit oor(input int x);
        return (x > Q - 1) || (x < -(Q - 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ok_in"}, 32'(ok_in), 0);
        check({tag, "_ok_out"}, 32'(ok_out), 0);
        check({tag, "_dout_1"}, 32'(dout_1), 0);
        check({tag, "_dout_2"}, 32'(dout_2), 0);
        check({tag, "_addr"}, 32'(dout_addr), 0);
        check({tag, "_dv"}, 32'(dout_valid), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(range_err), 0);
    endtask

    task automatic gen_small();
        for (int k = 0; k < NP; k++) begin
            d1[k] = int'($urandom_range(0, 6)) - 3;
            d2[k] = int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 7) == 0)
                d1[k] = int'($urandom_range(0, 6656)) - 3328;
        end
    endtask

    task automatic fill_poly(input int n, input bit gaps, input bit rd_noise);
        for (int k = 0; k < n; k++) begin
            readout = rd_noise;
            if (gaps) begin
                din_valid = 1'b0;
                cbd_din_1 = 16'($urandom);
                cbd_din_2 = 16'($urandom);
                step();
                check("fill_gap_ok_in", 32'(ok_in), 1);
                check("fill_gap_dv", 32'(dout_valid), 0);
            end
            din_valid = 1'b1;
            cbd_din_1 = 16'(d1[k]);
            cbd_din_2 = 16'(d2[k]);
            check("fill_ok_in", 32'(ok_in), 1);
            step();
            if (oor(d1[k]) || oor(d2[k])) exp_err = 1'b1;
            check("fill_err", 32'(range_err), 32'(exp_err));
            check("fill_dv", 32'(dout_valid), 0);
        end
        din_valid = 1'b0;
        readout   = 1'b0;
        if (n == NP) begin
            check("full_ok_in", 32'(ok_in), 0);
            check("full_ok_out", 32'(ok_out), 1);
        end
    endtask

    task automatic drain_poly(input int n, input bit gaps, input bit wr_noise);
        for (int k = 0; k < n; k++) begin
            din_valid = wr_noise;
            cbd_din_1 = 16'($urandom);
            cbd_din_2 = 16'($urandom);
            if (gaps && $urandom_range(0, 2) == 0) begin
                readout = 1'b0;
                step();
                check("gap_dv", 32'(dout_valid), 0);
                check("gap_ok_out", 32'(ok_out), 1);
                check("gap_done", 32'(done), 0);
                if (k > 0) check("gap_addr_hold", 32'(dout_addr), 32'(k - 1));
            end
            readout = 1'b1;
            step();
            check("pop_dv", 32'(dout_valid), 1);
            check("pop_addr", 32'(dout_addr), 32'(k));
            check("pop_d1", 32'(dout_1), 32'(red(d1[k])));
            check("pop_d2", 32'(dout_2), 32'(red(d2[k])));
            check("pop_done", 32'(done), 32'(k == NP - 1));
            check("pop_ok_out", 32'(ok_out), 32'(k != NP - 1));
            check("pop_ok_in", 32'(ok_in), 32'(k == NP - 1));
            check("pop_err", 32'(range_err), 32'(exp_err));
        end
        readout   = 1'b0;
        din_valid = 1'b0;
        if (n == NP) begin
            step();
            check("post_done", 32'(done), 0);
            check("post_dv", 32'(dout_valid), 0);
            check("post_ok_in", 32'(ok_in), 1);
        end
    endtask

    initial begin
        reset     = 1'b0;
        set       = 1'b0;
        din_valid = 1'b0;
        readout   = 1'b0;
        cbd_din_1 = '0;
        cbd_din_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");

        reset = 1'b1;
        step();
        check("idle_ok_in", 32'(ok_in), 0);
        set = 1'b1;
        step();
        check("start_ok_in", 32'(ok_in), 1);
        check("start_ok_out", 32'(ok_out), 0);

        // cyclic small pattern, continuous fill and drain
        for (int k = 0; k < NP; k++) begin
            d1[k] = (k % 5) - 2;
            d2[k] = -((k % 5) - 2);
        end
        fill_poly(NP, 1'b0, 1'b0);
        drain_poly(NP, 1'b0, 1'b0);
        check("pattern_no_err", 32'(range_err), 0);

        // random data, toggling din_valid and random readout gaps
        gen_small();
        fill_poly(NP, 1'b1, 1'b0);
        drain_poly(NP, 1'b1, 1'b0);

        // boundary values and an out-of-range pair at index 5
        for (int k = 0; k < NP; k++) begin
            d1[k] = -3328;
            d2[k] = 3328;
        end
        d1[5] = -3329;
        d2[5] = 3329;
        fill_poly(NP, 1'b0, 1'b0);
        drain_poly(NP, 1'b0, 1'b0);
        check("sticky_err", 32'(range_err), 1);

        // stray readout during fill, stray din_valid during drain
        gen_small();
        fill_poly(NP, 1'b0, 1'b1);
        drain_poly(NP, 1'b1, 1'b1);

        // abort fill at pair 60 with set low, then a fresh polynomial
        gen_small();
        fill_poly(60, 1'b0, 1'b0);
        set = 1'b0;
        step();
        exp_err = 1'b0;
        check("abort_ok_in", 32'(ok_in), 0);
        check("abort_ok_out", 32'(ok_out), 0);
        check("abort_err", 32'(range_err), 0);
        set = 1'b1;
        step();
        check("restart_ok_in", 32'(ok_in), 1);
        gen_small();
        fill_poly(NP, 1'b0, 1'b0);
        drain_poly(NP, 1'b0, 1'b0);

        // asynchronous reset in the middle of a drain
        gen_small();
        fill_poly(NP, 1'b0, 1'b0);
        drain_poly(40, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        reset = 1'b1;
        exp_err = 1'b0;
        step();
        check("post_rst_ok_in", 32'(ok_in), 1);
        check("post_rst_ok_out", 32'(ok_out), 0);
        gen_small();
        fill_poly(NP, 1'b0, 1'b0);
        drain_poly(NP, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbd_poly_buffer.md
# cbd_poly_buffer

Downstream stage of the dual-lane CBD sampler. Accepts pairs of signed 16-bit noise coefficients, reduces each to the canonical range [0, Q), and collects one full polynomial (N coefficients) in an internal pair buffer. Once full, it streams the polynomial out in index order to the NTT/poly-arithmetic stage under an explicit pull handshake. Single buffer: fill and drain phases never overlap.

## Interface

- Q, 3329, modulus added to negative coefficients
- N, 256, coefficients per polynomial (even; buffer depth N/2 pairs)
- DW, 12, output coefficient width (ceil(log2 Q))

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- set  in  1  block enable; low forces IDLE and clears counters
- cbd_din_1  in  16  signed coefficient, even index 2k
- cbd_din_2  in  16  signed coefficient, odd index 2k+1
- din_valid  in  1  input pair valid this cycle
- ok_in  out  1  block can accept a pair this cycle
- readout  in  1  consumer pops one pair this cycle
- ok_out  out  1  buffer holds a complete polynomial, pair available
- dout_1  out  DW  reduced coefficient, even index
- dout_2  out  DW  reduced coefficient, odd index
- dout_addr  out  log2(N/2)  pair index of dout_1/dout_2
- dout_valid  out  1  dout_* valid this cycle
- done  out  1  one-cycle pulse after last pair is popped
- range_err  out  1  sticky: an input outside [-(Q-1), Q-1] was accepted

## Operation

- States: IDLE, FILL, DRAIN.
- IDLE: ok_in=0, ok_out=0. set=1 -> FILL next edge.
- FILL: ok_in=1. Transfer when din_valid && ok_in. Each transfer writes reduced pair to buffer[wr_cnt], wr_cnt++. Transfer with wr_cnt=N/2-1 -> DRAIN next edge, wr_cnt wraps to 0, ok_in drops same edge.
- DRAIN: ok_out=1 while rd_cnt < N/2. Pop when readout && ok_out: dout_1/dout_2/dout_addr load buffer[rd_cnt], rd_cnt++. Pop at rd_cnt=N/2-1 -> done=1 next cycle, state -> FILL next edge if set=1, else IDLE.
- din_valid outside FILL ignored, no write, no error. readout outside DRAIN ignored, dout_valid stays 0.
- Reduction per lane: r = (x < 0) ? x + Q : x; stored low DW bits. Exact for x in [-(Q-1), Q-1]; CBD outputs (|x| <= 3) always in range.
- Out-of-range input (x < -(Q-1) or x > Q-1) on either lane of an accepted pair: stored value = reduction formula truncated to DW bits, range_err set; cleared only by reset or set=0.
- set=0 in any state: next edge -> IDLE, wr_cnt=rd_cnt=0, ok_in=ok_out=dout_valid=done=0, range_err cleared; buffer contents not cleared (don't-care).
- Reset mid-operation: same as set=0 but asynchronous; buffer contents don't-care.

## Timing

- Reset values: ok_in=0, ok_out=0, dout_1=0, dout_2=0, dout_addr=0, dout_valid=0, done=0, range_err=0, state IDLE.
- ok_in, ok_out are registered state decodes; no combinational path from din_valid/readout.
- Input: one pair per cycle sustained; N/2 consecutive cycles fill a polynomial (128 for N=256).
- Output latency: pop accepted at edge t -> dout_* and dout_valid=1 valid after edge t+1, held until next pop; dout_valid=0 on cycles without a pop.
- Back-to-back pops give one pair per cycle; full drain in N/2 cycles.
- FILL->DRAIN: ok_out=1 on cycle after the last write; first pop possible that cycle.
- DRAIN->FILL: ok_in=1 on cycle after last pop (same cycle as done pulse). Minimum period per polynomial: N/2 + N/2 + 0 gap cycles = N cycles.
- set deassert and last-pair event on same edge: set wins, IDLE, no done.

## Test plan

- Reset then set=1, 128 pairs din=(k mod 5 - 2, -(k mod 5 - 2)) back-to-back -> ok_in drops after 128th, ok_out=1; pops return e.g. pair 1: (3328, 1), pair 2: (0, 0), pair 3: (1, 3328); dout_addr 0..127; done pulses once.
- Fill with din_valid toggling every other cycle and readout with random gaps -> ordering, dout_addr and values unchanged vs. continuous run; dout_valid only after accepted pops.
- Inputs (-3329, 3329) at pair 5 -> range_err=1 and stays 1 through drain; (-3328, 3328) elsewhere -> (1, 3328), no error.
- readout=1 during FILL and din_valid=1 during DRAIN -> no pops, no writes, wr_cnt/rd_cnt unaffected, second polynomial reads correctly.
- set=0 at pair 60 of FILL, then set=1 and full fill -> pair 0 is first new pair, no stale data, range_err cleared.
- Reset asserted mid-DRAIN (pair 40) -> all outputs 0 immediately; after release with set=1, state FILL, ok_in=1 next cycle.
